piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready handshake
//  and shifts it out one bit per clock. It is the sending end of the serial link whose

---
 rtl/piso_serializer_if.sv | 22 ++
 rtl/piso_serializer.sv | 141 ++++++++++++++
 tb/tb_piso_serializer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the parallel-in/serial-out transmitter.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per frame, one bit per clock.
// Optional feature: define PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);

`ifdef PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The shift register always presents the next bit at its MSB, so bit order is fixed at load.
  function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        r[i] = d[WIDTH-1-i];
      end
    end else begin
      r = d;
    end
    return r;
  endfunction

`ifdef PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  function automatic logic [FL-1:0] build_frame(input logic [WIDTH-1:0] d);
    return {order_bits(d), even_parity(d)};
  endfunction
`else
  function automatic logic [FL-1:0] build_frame(input logic [WIDTH-1:0] d);
    return order_bits(d);
  endfunction
`endif

  state_t         state_r, state_s;
  logic [FL-1:0]  shreg_r, shreg_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           sout_r, sout_s;
  logic           sout_valid_r, sout_valid_s;
  logic           last_s;
  logic           ready_s;
  logic           accept_s;
  logic [FL-1:0]  frame_s;

  assign last_s   = (state_r == SHIFT) && (cnt_r == LAST_IDX);
  assign ready_s  = (state_r == IDLE) || last_s;
  assign accept_s = bus.load_valid && ready_s;
  assign frame_s  = build_frame(bus.din);

  // State, shift register, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      shreg_r      <= '0;
      cnt_r        <= '0;
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      cnt_r        <= cnt_s;
      sout_r       <= sout_s;
      sout_valid_r <= sout_valid_s;
    end
  end

  // Next-state and datapath: an accept always wins, including in the last-bit cycle.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    cnt_s        = cnt_r;
    sout_s       = sout_r;
    sout_valid_s = sout_valid_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s      = SHIFT;
          shreg_s      = {frame_s[FL-2:0], 1'b0};
          cnt_s        = '0;
          sout_s       = frame_s[FL-1];
          sout_valid_s = 1'b1;
        end else begin
          state_s      = IDLE;
        end
      end
      SHIFT: begin
        if (accept_s) begin
          state_s      = SHIFT;
          shreg_s      = {frame_s[FL-2:0], 1'b0};
          cnt_s        = '0;
          sout_s       = frame_s[FL-1];
          sout_valid_s = 1'b1;
        end else if (last_s) begin
          state_s      = IDLE;
          shreg_s      = '0;
          cnt_s        = '0;
          sout_s       = 1'b0;
          sout_valid_s = 1'b0;
        end else begin
          state_s      = SHIFT;
          shreg_s      = {shreg_r[FL-2:0], 1'b0};
          cnt_s        = cnt_r + CW'(1);
          sout_s       = shreg_r[FL-1];
          sout_valid_s = 1'b1;
        end
      end
      default: begin
        state_s      = IDLE;
        shreg_s      = '0;
        cnt_s        = '0;
        sout_s       = 1'b0;
        sout_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.sout       = sout_r;
  assign bus.sout_valid = sout_valid_r;
  assign bus.busy       = (state_r == SHIFT);
  assign bus.done       = sout_valid_r && last_s;
  assign bus.load_ready = ready_s;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances driven in lockstep.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FL  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = W;
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } fbit_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_msb;
    logic [7:0] seq_lsb;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) if_m ();
  piso_serializer_if #(.WIDTH(W)) if_l ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

  fbit_t q_m[$];
  fbit_t q_l[$];
  logic  cap_m[$];
  logic  cap_l[$];
  int    done_m, done_l;
  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[7];

  // Reference: a frame is the data bits in the chosen order, then optionally even parity.
  function automatic logic [31:0] frame_vec(input logic [W-1:0] d, input bit msb);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < W; i++) v = (v << 1) | 32'(msb ? d[W-1-i] : d[i]);
    if (PAR) v = (v << 1) | 32'(^d);
    return v;
  endfunction

  function automatic void push_frame(input bit msb, input logic [W-1:0] d);
    logic [31:0] v;
    fbit_t e;
    v = frame_vec(d, msb);
    for (int i = FL - 1; i >= 0; i--) begin
      e.b    = v[i];
      e.last = (i == 0);
      if (msb) q_m.push_back(e);
      else     q_l.push_back(e);
    end
  endfunction

  // Expected {sout, sout_valid, busy, done, load_ready} for the current cycle.
  function automatic logic [4:0] expect_vec(input bit msb);
    fbit_t h;
    int n;
    n = msb ? q_m.size() : q_l.size();
    if (n == 0) return 5'b00001;
    h = msb ? q_m[0] : q_l[0];
    return {h.b, 1'b1, 1'b1, h.last, (n == 1)};
  endfunction

  function automatic logic [31:0] cap_vec(input bit msb);
    logic [31:0] v;
    v = 32'd0;
    if (msb) foreach (cap_m[i]) v = (v << 1) | 32'(cap_m[i]);
    else     foreach (cap_l[i]) v = (v << 1) | 32'(cap_l[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_caps();
    cap_m.delete();
    cap_l.delete();
    done_m = 0;
    done_l = 0;
  endtask

  // Called just after a falling edge: check, capture, drive, advance model, move one cycle.
  task automatic cycle(input logic [W-1:0] d, input logic lv);
    bit rdy_m, rdy_l;
    check("outs_msb", 32'({if_m.sout, if_m.sout_valid, if_m.busy, if_m.done, if_m.load_ready}),
          32'(expect_vec(1'b1)));
    check("outs_lsb", 32'({if_l.sout, if_l.sout_valid, if_l.busy, if_l.done, if_l.load_ready}),
          32'(expect_vec(1'b0)));
    if (if_m.sout_valid) cap_m.push_back(if_m.sout);
    if (if_l.sout_valid) cap_l.push_back(if_l.sout);
    if (if_m.done) done_m++;
    if (if_l.done) done_l++;
    if_m.din = d;  if_m.load_valid = lv;
    if_l.din = d;  if_l.load_valid = lv;
    rdy_m = (q_m.size() <= 1);
    rdy_l = (q_l.size() <= 1);
    if (q_m.size() > 0) void'(q_m.pop_front());
    if (q_l.size() > 0) void'(q_l.pop_front());
    if (lv && rdy_m && rst_n) push_frame(1'b1, d);
    if (lv && rdy_l && rst_n) push_frame(1'b0, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input string name, input logic [31:0] exp_m, input logic [31:0] exp_l,
                             input int len, input int ndone);
    check({name, "_bits_msb"}, cap_vec(1'b1), exp_m);
    check({name, "_bits_lsb"}, cap_vec(1'b0), exp_l);
    check({name, "_len_msb"}, 32'(cap_m.size()), 32'(len));
    check({name, "_len_lsb"}, 32'(cap_l.size()), 32'(len));
    check({name, "_done_msb"}, 32'(done_m), 32'(ndone));
    check({name, "_done_lsb"}, 32'(done_l), 32'(ndone));
  endtask

  initial begin
    logic [31:0] em, el;
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{8'hD2, 8'hD2, 8'h4B, 1'b0};
    tbl[2] = '{8'h01, 8'h01, 8'h80, 1'b1};
    tbl[3] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
    tbl[4] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0};

    if_m.din = '0; if_m.load_valid = 1'b0;
    if_l.din = '0; if_l.load_valid = 1'b0;
    clear_caps();
    @(negedge clk);
    cycle(8'h00, 1'b0);
    rst_n = 1'b1;
    cycle(8'h00, 1'b0);

    // Single frames from the hand-written table.
    for (int t = 0; t < 7; t++) begin
      clear_caps();
      cycle(tbl[t].din, 1'b1);
      repeat (FL) cycle(W'($urandom), 1'b0);
      cycle(8'h00, 1'b0);
      em = 32'(tbl[t].seq_msb);
      el = 32'(tbl[t].seq_lsb);
      if (PAR) begin
        em = (em << 1) | 32'(tbl[t].par);
        el = (el << 1) | 32'(tbl[t].par);
      end
      check_frame("table", em, el, FL, 1);
    end

    // Back-to-back: load_valid held through 8'h01 and then 8'hFF.
    clear_caps();
    cycle(8'h01, 1'b1);
    repeat (FL) cycle(8'hFF, 1'b1);
    repeat (FL) cycle(8'hFF, 1'b0);
    cycle(8'h00, 1'b0);
    check_frame("b2b", (frame_vec(8'h01, 1'b1) << FL) | frame_vec(8'hFF, 1'b1),
                (frame_vec(8'h01, 1'b0) << FL) | frame_vec(8'hFF, 1'b0), 2 * FL, 2);

    // Load offered mid-frame is ignored.
    clear_caps();
    cycle(8'hA5, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b1);
    repeat (FL - 3) cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    check_frame("ignore", frame_vec(8'hA5, 1'b1), frame_vec(8'hA5, 1'b0), FL, 1);
    check("ignore_idle_busy", 32'(if_m.busy), 32'd0);

    // Asynchronous reset after three bits of 8'hA5, then a clean 8'h0F frame.
    clear_caps();
    cycle(8'hA5, 1'b1);
    repeat (3) cycle(8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_msb", 32'({if_m.sout, if_m.sout_valid, if_m.busy, if_m.done, if_m.load_ready}),
          32'(5'b00001));
    check("async_rst_lsb", 32'({if_l.sout, if_l.sout_valid, if_l.busy, if_l.done, if_l.load_ready}),
          32'(5'b00001));
    q_m.delete();
    q_l.delete();
    check_frame("abort", 32'b101, 32'b101, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_caps();
    cycle(8'h0F, 1'b1);
    repeat (FL) cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
    check_frame("after_rst", frame_vec(8'h0F, 1'b1), frame_vec(8'h0F, 1'b0), FL, 1);

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      cycle(W'($urandom), ($urandom_range(0, 9) < 6));
    end
    repeat (FL + 1) cycle(8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
